// File: rtl/mc_controller_if.sv
// ---------------------------------------------------------------------------
// mc_controller_if
// Bundle between the multi-cycle MIPS sequencer and the datapath it steers.
//
// Signals (direction seen from the controller, modport master):
//   op, funct   in  6  IR[31:26] / IR[5:0]
//   alu_eq      in  1  GRF RD1 == RD2
//   mem_ready   in  1  data memory completed the current access
//   ir_we       out 1  load IR from IM
//   pc_we       out 1  load PC
//   pc_src      out 2  0=PC+4 1=branch target 2=jump target 3=RD1
//   reg_we      out 1  GRF write enable
//   reg_dst     out 2  0=rt 1=rd 2=$31
//   wd_src      out 2  0=ALU 1=DM RD 2=PC
//   alu_src     out 1  0=RD2 1=Ext32
//   ext_op      out 2  0=zero 1=sign 2=imm<<16
//   alu_op      out 4  0=add 1=sub 2=or
//   mem_req     out 1  DM access request
//   mem_we      out 1  DM write (qualified by mem_req)
//   instr_done  out 1  retire pulse
//   trap        out 1  sticky watchdog flag
//   state       out 3  current sequencer state
// The slave modport is the datapath / memory side.
// ---------------------------------------------------------------------------
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       alu_eq;
    logic       mem_ready;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_src;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       instr_done;
    logic       trap;
    logic [2:0] state;

    modport master (
        input  op, funct, alu_eq, mem_ready,
        output ir_we, pc_we, pc_src, reg_we, reg_dst, wd_src, alu_src,
               ext_op, alu_op, mem_req, mem_we, instr_done, trap, state
    );

    modport slave (
        output op, funct, alu_eq, mem_ready,
        input  ir_we, pc_we, pc_src, reg_we, reg_dst, wd_src, alu_src,
               ext_op, alu_op, mem_req, mem_we, instr_done, trap, state
    );
endinterface

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multi-cycle sequencer for a MIPS datapath. Each instruction walks through
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; per-state enables and mux selects
// let one ALU and one memory port serve the whole instruction. Data memory
// accesses use a req/ready handshake with variable latency, guarded by a
// watchdog that parks the sequencer in TRAP if the memory never answers.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-low reset
//   bus    mc_controller_if.master (opcode fields in, control signals out)
//
// Parameters:
//   WAIT_LIMIT  stalled MEM cycles tolerated before TRAP (>= 1)
//   CNT_W       wait counter width, 2**CNT_W > WAIT_LIMIT
// ---------------------------------------------------------------------------
module mc_controller #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ADDU, CL_SUBU, CL_ORI, CL_LUI, CL_LW, CL_SW,
        CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_JALR
    } class_t;

    localparam logic [3:0]       ALU_ADD  = 4'd0;
    localparam logic [3:0]       ALU_SUB  = 4'd1;
    localparam logic [3:0]       ALU_OR   = 4'd2;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    function automatic class_t decode_class(input logic [5:0] op, input logic [5:0] funct);
        class_t c;
        c = CL_NOP;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   c = CL_ADDU;
                    6'h23:   c = CL_SUBU;
                    6'h08:   c = CL_JR;
                    6'h09:   c = CL_JALR;
                    default: c = CL_NOP;
                endcase
            end
            6'h0D:   c = CL_ORI;
            6'h0F:   c = CL_LUI;
            6'h23:   c = CL_LW;
            6'h2B:   c = CL_SW;
            6'h04:   c = CL_BEQ;
            6'h05:   c = CL_BNE;
            6'h02:   c = CL_J;
            6'h03:   c = CL_JAL;
            default: c = CL_NOP;
        endcase
        return c;
    endfunction

    state_t           state_reg, state_next;
    class_t           cls_reg, cls_dec, cls_sel;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic       ir_we_reg,   ir_we_next;
    logic       pc_we_reg,   pc_we_next;
    logic [1:0] pc_src_reg,  pc_src_next;
    logic       reg_we_reg,  reg_we_next;
    logic [1:0] reg_dst_reg, reg_dst_next;
    logic [1:0] wd_src_reg,  wd_src_next;
    logic       alu_src_reg, alu_src_next;
    logic [1:0] ext_op_reg,  ext_op_next;
    logic [3:0] alu_op_reg,  alu_op_next;
    logic       mem_req_reg, mem_req_next;
    logic       mem_we_reg,  mem_we_next;
    logic       done_reg,    done_next;
    logic       trap_reg,    trap_next;
    // Branch qualifiers: the compare result is only known during EXEC, so
    // the PC write for beq/bne is gated by alu_eq in that same cycle.
    logic       br_eq_reg,   br_eq_next;
    logic       br_ne_reg,   br_ne_next;

    // Next-state and watchdog counter.
    always_comb begin
        cls_dec       = decode_class(bus.op, bus.funct);
        // While in DECODE the class is not latched yet; the EXEC controls
        // registered at the end of DECODE must use the freshly decoded value.
        cls_sel       = (state_reg == ST_DECODE) ? cls_dec : cls_reg;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                case (cls_reg)
                    CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state_next = ST_WB;
                    CL_LW, CL_SW:                     state_next = ST_MEM;
                    default:                          state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    wait_cnt_next = '0;
                    state_next    = (cls_reg == CL_LW) ? ST_WB : ST_FETCH;
                end else if (wait_cnt_reg == LIMIT_M1) begin
                    // This is the WAIT_LIMIT-th consecutive stalled cycle.
                    wait_cnt_next = '0;
                    state_next    = ST_TRAP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Control values for the state being entered; registered so every
    // output is glitch-free and clears the instant reset asserts.
    always_comb begin
        ir_we_next   = 1'b0;
        pc_we_next   = 1'b0;
        pc_src_next  = 2'd0;
        reg_we_next  = 1'b0;
        reg_dst_next = 2'd0;
        wd_src_next  = 2'd0;
        alu_src_next = 1'b0;
        ext_op_next  = 2'd0;
        alu_op_next  = ALU_ADD;
        mem_req_next = 1'b0;
        mem_we_next  = 1'b0;
        done_next    = 1'b0;
        trap_next    = 1'b0;
        br_eq_next   = 1'b0;
        br_ne_next   = 1'b0;
        case (state_next)
            ST_FETCH: begin
                ir_we_next  = 1'b1;
                pc_we_next  = 1'b1;
                pc_src_next = 2'd0;
            end
            ST_EXEC: begin
                case (cls_sel)
                    CL_ADDU: alu_op_next = ALU_ADD;
                    CL_SUBU: alu_op_next = ALU_SUB;
                    CL_ORI: begin
                        alu_src_next = 1'b1;
                        ext_op_next  = 2'd0;
                        alu_op_next  = ALU_OR;
                    end
                    CL_LUI: begin
                        alu_src_next = 1'b1;
                        ext_op_next  = 2'd2;
                        alu_op_next  = ALU_OR;
                    end
                    CL_LW, CL_SW: begin
                        alu_src_next = 1'b1;
                        ext_op_next  = 2'd1;
                        alu_op_next  = ALU_ADD;
                    end
                    CL_BEQ: begin
                        br_eq_next  = 1'b1;
                        pc_src_next = 2'd1;
                        done_next   = 1'b1;
                    end
                    CL_BNE: begin
                        br_ne_next  = 1'b1;
                        pc_src_next = 2'd1;
                        done_next   = 1'b1;
                    end
                    CL_J: begin
                        pc_we_next  = 1'b1;
                        pc_src_next = 2'd2;
                        done_next   = 1'b1;
                    end
                    CL_JAL: begin
                        pc_we_next   = 1'b1;
                        pc_src_next  = 2'd2;
                        reg_we_next  = 1'b1;
                        reg_dst_next = 2'd2;
                        wd_src_next  = 2'd2;
                        done_next    = 1'b1;
                    end
                    CL_JR: begin
                        pc_we_next  = 1'b1;
                        pc_src_next = 2'd3;
                        done_next   = 1'b1;
                    end
                    CL_JALR: begin
                        // The GRF write and the PC load share one edge, so
                        // the jump target is the RD1 value read before it.
                        pc_we_next   = 1'b1;
                        pc_src_next  = 2'd3;
                        reg_we_next  = 1'b1;
                        reg_dst_next = 2'd1;
                        wd_src_next  = 2'd2;
                        done_next    = 1'b1;
                    end
                    default: done_next = 1'b1;
                endcase
            end
            ST_MEM: begin
                mem_req_next = 1'b1;
                mem_we_next  = (cls_sel == CL_SW);
            end
            ST_WB: begin
                reg_we_next = 1'b1;
                done_next   = 1'b1;
                case (cls_sel)
                    CL_ADDU, CL_SUBU: begin
                        reg_dst_next = 2'd1;
                        wd_src_next  = 2'd0;
                    end
                    CL_LW: begin
                        reg_dst_next = 2'd0;
                        wd_src_next  = 2'd1;
                    end
                    default: begin
                        reg_dst_next = 2'd0;
                        wd_src_next  = 2'd0;
                    end
                endcase
            end
            ST_TRAP: trap_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cls_reg      <= CL_NOP;
            wait_cnt_reg <= '0;
            ir_we_reg    <= 1'b0;
            pc_we_reg    <= 1'b0;
            pc_src_reg   <= 2'd0;
            reg_we_reg   <= 1'b0;
            reg_dst_reg  <= 2'd0;
            wd_src_reg   <= 2'd0;
            alu_src_reg  <= 1'b0;
            ext_op_reg   <= 2'd0;
            alu_op_reg   <= 4'd0;
            mem_req_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            done_reg     <= 1'b0;
            trap_reg     <= 1'b0;
            br_eq_reg    <= 1'b0;
            br_ne_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            if (state_reg == ST_DECODE) begin
                cls_reg <= cls_dec;
            end
            wait_cnt_reg <= wait_cnt_next;
            ir_we_reg    <= ir_we_next;
            pc_we_reg    <= pc_we_next;
            pc_src_reg   <= pc_src_next;
            reg_we_reg   <= reg_we_next;
            reg_dst_reg  <= reg_dst_next;
            wd_src_reg   <= wd_src_next;
            alu_src_reg  <= alu_src_next;
            ext_op_reg   <= ext_op_next;
            alu_op_reg   <= alu_op_next;
            mem_req_reg  <= mem_req_next;
            mem_we_reg   <= mem_we_next;
            done_reg     <= done_next;
            trap_reg     <= trap_next;
            br_eq_reg    <= br_eq_next;
            br_ne_reg    <= br_ne_next;
        end
    end

    assign bus.state      = state_reg;
    assign bus.ir_we      = ir_we_reg;
    assign bus.pc_we      = pc_we_reg | (br_eq_reg & bus.alu_eq) | (br_ne_reg & ~bus.alu_eq);
    assign bus.pc_src     = pc_src_reg;
    assign bus.reg_we     = reg_we_reg;
    assign bus.reg_dst    = reg_dst_reg;
    assign bus.wd_src     = wd_src_reg;
    assign bus.alu_src    = alu_src_reg;
    assign bus.ext_op     = ext_op_reg;
    assign bus.alu_op     = alu_op_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_we     = mem_we_reg;
    // A store retires in the very MEM cycle its ready arrives.
    assign bus.instr_done = done_reg |
                            ((state_reg == ST_MEM) && (cls_reg == CL_SW) && bus.mem_ready);
    assign bus.trap       = trap_reg;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    localparam int WAIT_LIMIT = 16;

    // Bench-side instruction classes
    localparam int M_NOP = 0, M_ADDU = 1, M_SUBU = 2, M_ORI = 3, M_LUI = 4, M_LW = 5,
                   M_SW = 6, M_BEQ = 7, M_BNE = 8, M_J = 9, M_JAL = 10, M_JR = 11, M_JALR = 12;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [3:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       done;
        logic       trap;
    } outv_t;

    typedef struct {
        string      tag;
        logic [5:0] op;
        logic [5:0] funct;
        logic       alu_eq;
        logic       mem_ready;
        outv_t      exp;
    } rec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    rec_t sb[$];

    mc_controller_if bus ();

    mc_controller #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic outv_t observed();
        outv_t o;
        o.st      = bus.state;
        o.ir_we   = bus.ir_we;
        o.pc_we   = bus.pc_we;
        o.pc_src  = bus.pc_src;
        o.reg_we  = bus.reg_we;
        o.reg_dst = bus.reg_dst;
        o.wd_src  = bus.wd_src;
        o.alu_src = bus.alu_src;
        o.ext_op  = bus.ext_op;
        o.alu_op  = bus.alu_op;
        o.mem_req = bus.mem_req;
        o.mem_we  = bus.mem_we;
        o.done    = bus.instr_done;
        o.trap    = bus.trap;
        return o;
    endfunction

    function automatic int model_class(input logic [5:0] op, input logic [5:0] funct);
        if (op == 6'h00) begin
            if (funct == 6'h21) return M_ADDU;
            if (funct == 6'h23) return M_SUBU;
            if (funct == 6'h08) return M_JR;
            if (funct == 6'h09) return M_JALR;
            return M_NOP;
        end
        if (op == 6'h0D) return M_ORI;
        if (op == 6'h0F) return M_LUI;
        if (op == 6'h23) return M_LW;
        if (op == 6'h2B) return M_SW;
        if (op == 6'h04) return M_BEQ;
        if (op == 6'h05) return M_BNE;
        if (op == 6'h02) return M_J;
        if (op == 6'h03) return M_JAL;
        return M_NOP;
    endfunction

    task automatic push(input string tag, input logic [5:0] op, input logic [5:0] funct,
                        input logic eq, input logic rdy, input outv_t e);
        rec_t r;
        r.tag = tag; r.op = op; r.funct = funct; r.alu_eq = eq; r.mem_ready = rdy; r.exp = e;
        sb.push_back(r);
    endtask

    task automatic push_idle();
        outv_t e;
        e = '0;
        push("idle", 6'h00, 6'h00, 1'b0, 1'b0, e);
    endtask

    // Expected per-cycle outputs for one instruction. waits = stalled MEM
    // cycles; ready=0 abandons the access after the stalls (for reset tests);
    // noise drives mem_ready=1 in every non-MEM cycle.
    task automatic push_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                              input logic eq, input int waits, input bit ready, input bit noise);
        outv_t e;
        int    c;
        c = model_class(op, funct);
        e = '0; e.st = 3'd1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        push({name, "/fetch"}, op, funct, eq, noise, e);
        e = '0; e.st = 3'd2;
        push({name, "/decode"}, op, funct, eq, noise, e);
        e = '0; e.st = 3'd3;
        case (c)
            M_ADDU: e.alu_op = 4'd0;
            M_SUBU: e.alu_op = 4'd1;
            M_ORI:  begin e.alu_src = 1'b1; e.ext_op = 2'd0; e.alu_op = 4'd2; end
            M_LUI:  begin e.alu_src = 1'b1; e.ext_op = 2'd2; e.alu_op = 4'd2; end
            M_LW, M_SW: begin e.alu_src = 1'b1; e.ext_op = 2'd1; e.alu_op = 4'd0; end
            M_BEQ:  begin e.pc_we = eq;  e.pc_src = 2'd1; e.done = 1'b1; end
            M_BNE:  begin e.pc_we = !eq; e.pc_src = 2'd1; e.done = 1'b1; end
            M_J:    begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.done = 1'b1; end
            M_JAL:  begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.reg_we = 1'b1;
                          e.reg_dst = 2'd2; e.wd_src = 2'd2; e.done = 1'b1; end
            M_JR:   begin e.pc_we = 1'b1; e.pc_src = 2'd3; e.done = 1'b1; end
            M_JALR: begin e.pc_we = 1'b1; e.pc_src = 2'd3; e.reg_we = 1'b1;
                          e.reg_dst = 2'd1; e.wd_src = 2'd2; e.done = 1'b1; end
            default: e.done = 1'b1;
        endcase
        push({name, "/exec"}, op, funct, eq, noise, e);
        if (c == M_LW || c == M_SW) begin
            for (int i = 0; i < waits && i < WAIT_LIMIT; i++) begin
                e = '0; e.st = 3'd4; e.mem_req = 1'b1; e.mem_we = (c == M_SW);
                push($sformatf("%s/mem_wait%0d", name, i), op, funct, eq, 1'b0, e);
            end
            if (waits >= WAIT_LIMIT) begin
                for (int i = 0; i < 3; i++) begin
                    e = '0; e.st = 3'd7; e.trap = 1'b1;
                    push($sformatf("%s/trap%0d", name, i), op, funct, eq, 1'(i % 2), e);
                end
                return;
            end
            if (!ready) return;
            e = '0; e.st = 3'd4; e.mem_req = 1'b1; e.mem_we = (c == M_SW); e.done = (c == M_SW);
            push({name, "/mem_ready"}, op, funct, eq, 1'b1, e);
        end
        if (c == M_ADDU || c == M_SUBU || c == M_ORI || c == M_LUI || c == M_LW) begin
            e = '0; e.st = 3'd5; e.reg_we = 1'b1; e.done = 1'b1;
            if (c == M_ADDU || c == M_SUBU) e.reg_dst = 2'd1;
            if (c == M_LW) e.wd_src = 2'd1;
            push({name, "/wb"}, op, funct, eq, noise, e);
        end
    endtask

    // Called at a falling edge: drive the cycle's inputs, let them settle,
    // compare, then advance one clock.
    task automatic drain();
        rec_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            bus.op        = r.op;
            bus.funct     = r.funct;
            bus.alu_eq    = r.alu_eq;
            bus.mem_ready = r.mem_ready;
            #1;
            check_eq(r.tag, 32'(observed()), 32'(r.exp));
            if (r.exp.done) $display("txn %s retired", r.tag);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.op = 6'h00; bus.funct = 6'h00; bus.alu_eq = 1'b0; bus.mem_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_state", 32'(observed()), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        push_idle();
        push_instr("addu", 6'h00, 6'h21, 1'b0, 0, 1'b1, 1'b0);
        push_instr("lw_w3", 6'h23, 6'h00, 1'b0, 3, 1'b1, 1'b0);
        push_instr("beq_t", 6'h04, 6'h00, 1'b1, 0, 1'b1, 1'b0);
        push_instr("beq_nt", 6'h04, 6'h00, 1'b0, 0, 1'b1, 1'b0);
        push_instr("bne_t", 6'h05, 6'h00, 1'b0, 0, 1'b1, 1'b0);
        push_instr("bne_nt", 6'h05, 6'h00, 1'b1, 0, 1'b1, 1'b0);
        push_instr("jal", 6'h03, 6'h00, 1'b0, 0, 1'b1, 1'b0);
        push_instr("j", 6'h02, 6'h00, 1'b0, 0, 1'b1, 1'b1);
        push_instr("jr", 6'h00, 6'h08, 1'b0, 0, 1'b1, 1'b0);
        push_instr("jalr", 6'h00, 6'h09, 1'b0, 0, 1'b1, 1'b0);
        push_instr("ori", 6'h0D, 6'h00, 1'b0, 0, 1'b1, 1'b1);
        push_instr("lui", 6'h0F, 6'h00, 1'b0, 0, 1'b1, 1'b0);
        push_instr("subu", 6'h00, 6'h23, 1'b0, 0, 1'b1, 1'b1);
        push_instr("sw_w0", 6'h2B, 6'h00, 1'b0, 0, 1'b1, 1'b1);
        push_instr("lw_w0", 6'h23, 6'h00, 1'b0, 0, 1'b1, 1'b0);
        push_instr("sw_w2", 6'h2B, 6'h00, 1'b0, 2, 1'b1, 1'b0);
        push_instr("nop_r2a", 6'h00, 6'h2A, 1'b1, 0, 1'b1, 1'b1);
        push_instr("addu2", 6'h00, 6'h21, 1'b0, 0, 1'b1, 1'b0);
        drain();

        // Reset in the middle of a stalled load.
        push_instr("lw_abort", 6'h23, 6'h00, 1'b0, 2, 1'b0, 1'b0);
        drain();
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst_midmem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_midmem_all", 32'(observed()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        push_idle();
        push_instr("nop_3f", 6'h3F, 6'h00, 1'b0, 0, 1'b1, 1'b0);
        push_instr("lw_w1", 6'h23, 6'h00, 1'b0, 1, 1'b1, 1'b0);
        drain();

        // Store that never completes: watchdog trap, sticky until reset.
        push_instr("sw_hang", 6'h2B, 6'h00, 1'b0, WAIT_LIMIT, 1'b0, 1'b0);
        drain();
        reset = 1'b0;
        #1;
        check_eq("trap_clear", 32'(observed()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        push_idle();
        push_instr("addu_post", 6'h00, 6'h21, 1'b0, 0, 1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
